// File: rtl/cache_tag_array.sv
// Set-associative tag/metadata store: per-way valid+tag, true-LRU ages,
// registered lookup with hit/victim outputs and a set-by-set flush FSM.
module cache_tag_array #(
    parameter  int unsigned SETS  = 64,
    parameter  int unsigned WAYS  = 2,
    parameter  int unsigned TAG_W = 6,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [WAY_W-1:0] resp_hit_way,
    output logic [WAY_W-1:0] resp_victim_way,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [WAY_W-1:0] fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             flush_req,
    output logic             busy,
    output logic             flush_done
);

    localparam int unsigned AGE_W = WAY_W;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               req_valid_q, req_valid_d;
    logic [IDX_W-1:0]   req_idx_q, req_idx_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [AGE_W-1:0]   age_q   [SETS][WAYS];

    logic               idle_c;
    logic               fill_go_c;
    logic               hit_c;
    logic [WAY_W-1:0]   hit_way_c;
    logic [WAY_W-1:0]   victim_c;
    logic               hit_upd_c;
    logic [AGE_W-1:0]   hit_age_c  [WAYS];
    logic [AGE_W-1:0]   fill_age_c [WAYS];
    logic [AGE_W-1:0]   hit_old_c;
    logic [AGE_W-1:0]   fill_old_c;

    // Flush FSM and lookup capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy        = 1'b0;
        flush_done  = 1'b0;
        idle_c      = (state_q == ST_IDLE);
        req_valid_d = lookup_valid & idle_c;
        req_idx_d   = lookup_index;
        req_tag_d   = lookup_tag;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                busy  = 1'b1;
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    flush_done = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hit compare and victim choice against current array contents
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (age_q[req_idx_q][w] == AGE_W'(WAYS - 1)) begin
                victim_c = WAY_W'(w);
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[req_idx_q][w]) begin
                victim_c = WAY_W'(w);
            end
        end
    end

    assign resp_valid      = req_valid_q;
    assign resp_hit        = req_valid_q & hit_c;
    assign resp_hit_way    = req_valid_q ? hit_way_c : '0;
    assign resp_victim_way = req_valid_q ? victim_c : '0;

    assign fill_go_c = fill_en & idle_c;
    // A fill to the same set wins over the pending hit update
    assign hit_upd_c = req_valid_q & hit_c & idle_c &
                       ~(fill_go_c && (fill_index == req_idx_q));

    // True-LRU ages after touching the hit way and the fill way
    always_comb begin
        hit_old_c  = age_q[req_idx_q][hit_way_c];
        fill_old_c = age_q[fill_index][fill_way];
        for (int w = 0; w < int'(WAYS); w++) begin
            hit_age_c[w]  = age_q[req_idx_q][w];
            fill_age_c[w] = age_q[fill_index][w];
            if (WAY_W'(w) == hit_way_c) begin
                hit_age_c[w] = '0;
            end else if (age_q[req_idx_q][w] < hit_old_c) begin
                hit_age_c[w] = age_q[req_idx_q][w] + AGE_W'(1);
            end
            if (WAY_W'(w) == fill_way) begin
                fill_age_c[w] = '0;
            end else if (age_q[fill_index][w] < fill_old_c) begin
                fill_age_c[w] = age_q[fill_index][w] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_idx_q   <= '0;
            req_tag_q   <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            req_idx_q   <= req_idx_d;
            req_tag_q   <= req_tag_d;
            if (state_q == ST_FLUSH) begin
                valid_q[cnt_q] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[cnt_q][w] <= AGE_W'(w);
                end
            end
            if (hit_upd_c) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[req_idx_q][w] <= hit_age_c[w];
                end
            end
            if (fill_go_c) begin
                valid_q[fill_index][fill_way] <= 1'b1;
                for (int w = 0; w < int'(WAYS); w++) begin
                    age_q[fill_index][w] <= fill_age_c[w];
                end
            end
        end
    end

    // Tags are meaningless while invalid, so they carry no reset
    always_ff @(posedge clk) begin
        if (!rst && fill_go_c) begin
            tag_q[fill_index][fill_way] <= fill_tag;
        end
    end

endmodule

// File: doc/cache_tag_array.md
Name: cache_tag_array

Overview:
- Parametrised set-associative tag/metadata store for the cache.
- Successor to the flat one-hot, 8-bit-per-block metadata array: binary set index, per-way valid+tag, true-LRU age counters, registered lookup with hit compare and victim selection, multi-cycle flush FSM.
- Sits between the cache controller FSM and the data array; replaces tri-state readout with muxed, registered responses.

Parameters:
- SETS, 64, number of sets; power of 2, at least 2; IDX_W = clog2(SETS)
- WAYS, 2, associativity; power of 2, at least 2; WAY_W = AGE_W = clog2(WAYS)
- TAG_W, 6, tag width in bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- lookup_valid  in  1  lookup request this cycle
- lookup_index  in  IDX_W  set to look up
- lookup_tag  in  TAG_W  tag to compare
- resp_valid  out  1  lookup response valid (one cycle after request)
- resp_hit  out  1  tag matched a valid way
- resp_hit_way  out  WAY_W  matching way (0 when miss)
- resp_victim_way  out  WAY_W  replacement candidate for the looked-up set
- fill_en  in  1  install tag
- fill_index  in  IDX_W  set to fill
- fill_way  in  WAY_W  way to fill
- fill_tag  in  TAG_W  tag written
- flush_req  in  1  start invalidate-all
- busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse on last flush cycle

Behaviour:
- Storage per set/way: valid (1), tag (TAG_W), age (AGE_W). Age 0 = MRU, WAYS-1 = LRU; ages within a set are always a permutation of 0..WAYS-1.
- Reset, synchronous, single cycle: all valid=0, age[w]=w in every set, FSM=IDLE, resp_valid=0, resp_hit=0, resp_hit_way=0, resp_victim_way=0, busy=0, flush_done=0.
- Lookup pipeline: lookup_valid in cycle N captures index and tag at the edge. In cycle N+1 resp_valid=1, and compare/victim outputs are combinational against array contents during N+1, i.e. before any write at the end of N+1.
- Hit means exactly one valid way with equal tag. Fills must never create duplicates; duplicate-tag behaviour is undefined.
- Victim: lowest-numbered invalid way; if all are valid, the way with age WAYS-1.
- LRU update, for a hit in resp cycle or for a fill: touched way gets age 0; every way in that set with age below the touched way's old age increments; others unchanged.
- Fill: at the edge, valid=1, tag=fill_tag, plus LRU update for fill_way. Fill to an already-valid way overwrites it.
- Same-set collision: hit update and fill in the same cycle on the same set apply the fill LRU update only; hit update dropped. Different sets: both apply.
- Back-to-back lookups: one per cycle, fully pipelined. A lookup in N+1 sees LRU/fill writes made at the end of N+1 only in its own resp cycle N+2.
- Flush FSM:
  - IDLE: flush_req with busy=0 -> FLUSH, counter=0.
  - FLUSH: each cycle, set[counter] valid=0 and age[w]=w; counter++; busy=1.
  - When counter=SETS-1: flush_done=1 that cycle, next IDLE, busy=0.
  - Flush lasts exactly SETS cycles.
- During FLUSH:
  - lookup_valid and fill_en are ignored; no response is generated, resp_valid=0.
  - flush_req is ignored.
  - A lookup captured in the cycle flush_req is accepted still responds normally in the next cycle; its LRU update is dropped.
- rst in any state, including mid-flush: full clear, FSM=IDLE, counter=0, outputs at reset values next cycle.
- flush_req and fill_en together in IDLE: fill applied, then flush begins.

Test Plan (SETS=64, WAYS=2, TAG_W=6):
1. Reset; lookup idx 5 tag 0x2A -> next cycle resp_valid=1, hit=0, victim_way=0.
2. Fill idx 5 way 0 tag 0x2A; lookup idx 5 tag 0x2A -> hit=1, hit_way=0, victim_way=1 (way 1 invalid).
3. Fill idx 5 way 1 tag 0x11; lookup tag 0x2A (hit way 0, way 0 becomes MRU); lookup tag 0x3F -> hit=0, victim_way=1.
4. Same cycle: resp hit on idx 9 way 0, fill idx 9 way 1 -> way 1 MRU; next miss on idx 9 -> victim_way=0.
5. Fill idx 0, 5, 63; assert flush_req -> busy=1 for 64 cycles, flush_done only on the 64th, lookups during flush give resp_valid=0; afterwards, lookup idx 5 tag 0x2A -> hit=0, victim_way=0.
6. Fill idx 40; start flush, assert rst at flush cycle 10 -> next cycle busy=0, flush_done never pulses, idx 40 lookup misses.
